// File: rtl/sdp_wdma_cmd_sfifo_ctrl.sv
// sdp_wdma_cmd_sfifo_ctrl
//
// Control half of the SDP WDMA command skid FIFO. It holds 4 entries of 15-bit
// command payload and has a valid/ready handshake on both sides. This block
// keeps the write pointer, read pointer and occupancy count. The payload itself
// lives in a companion 4x15 flop RAM: this block drives that RAM's write and
// read ports and passes the RAM's combinational read data out as the FIFO head.
//
// Ports:
//   nvdla_core_clk / nvdla_core_rst  clock, synchronous active-high reset
//   wr_pvld / wr_prdy / wr_pd        upstream (command generator) handshake
//   rd_pvld / rd_prdy / rd_pd        downstream (request packer) handshake
//   ram_we / ram_wa / ram_di         flop RAM write port
//   ram_ra / ram_dout                flop RAM read port (combinational read)
//   pwrbus_ram_pd                    RAM power bus; the parent routes it, unused here
//   fifo_count / fifo_idle           occupancy (0..4) and idle status

module sdp_wdma_cmd_sfifo_ctrl #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 15
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rst,
    input  logic             wr_pvld,
    output logic             wr_prdy,
    input  logic [WIDTH-1:0] wr_pd,
    output logic             rd_pvld,
    input  logic             rd_prdy,
    output logic [WIDTH-1:0] rd_pd,
    output logic             ram_we,
    output logic [1:0]       ram_wa,
    output logic [WIDTH-1:0] ram_di,
    output logic [2:0]       ram_ra,
    input  logic [WIDTH-1:0] ram_dout,
    input  logic [31:0]      pwrbus_ram_pd,
    output logic [2:0]       fifo_count,
    output logic             fifo_idle
);

    logic [1:0] wr_adr_q, wr_adr_d;
    logic [1:0] rd_adr_q, rd_adr_d;
    logic [2:0] count_q,  count_d;
    logic       wr_accept;
    logic       rd_accept;
    logic       unused_pwrbus;

    assign unused_pwrbus = ^pwrbus_ram_pd;

    // wr_prdy looks only at the registered count, never at rd_prdy, so there
    // is no combinational path from the read side to the write side.
    assign wr_prdy   = !nvdla_core_rst && (count_q != 3'(DEPTH));
    assign wr_accept = wr_pvld && wr_prdy;
    assign rd_pvld   = (count_q != 3'd0);
    assign rd_accept = rd_pvld && rd_prdy;

    assign ram_we     = wr_accept;
    assign ram_wa     = wr_adr_q;
    assign ram_di     = wr_pd;
    // Bit 2 selects the RAM's write-data bypass, which is never used: a write
    // only becomes visible on the read side one cycle later.
    assign ram_ra     = {1'b0, rd_adr_q};
    assign rd_pd      = ram_dout;
    assign fifo_count = count_q;
    assign fifo_idle  = (count_q == 3'd0) && !wr_pvld;

    // The 2-bit pointers wrap naturally. Full and empty are told apart by the
    // count, not by comparing the pointers.
    always_comb begin
        wr_adr_d = wr_adr_q;
        rd_adr_d = rd_adr_q;
        count_d  = count_q;
        if (wr_accept) begin
            wr_adr_d = wr_adr_q + 2'd1;
        end
        if (rd_accept) begin
            rd_adr_d = rd_adr_q + 2'd1;
        end
        case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            wr_adr_q <= 2'd0;
            rd_adr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            wr_adr_q <= wr_adr_d;
            rd_adr_q <= rd_adr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_sdp_wdma_cmd_sfifo_ctrl.sv
module tb_sdp_wdma_cmd_sfifo_ctrl;

    logic        clk;
    logic        rst;
    logic        wr_pvld;
    logic        wr_prdy;
    logic [14:0] wr_pd;
    logic        rd_pvld;
    logic        rd_prdy;
    logic [14:0] rd_pd;
    logic        ram_we;
    logic [1:0]  ram_wa;
    logic [14:0] ram_di;
    logic [2:0]  ram_ra;
    logic [14:0] ram_dout;
    logic [31:0] pwrbus_ram_pd;
    logic [2:0]  fifo_count;
    logic        fifo_idle;

    int checks = 0;
    int errors = 0;

    // Flop RAM stand-in: registered write, combinational read.
    logic [14:0] mem [4];
    assign ram_dout = mem[ram_ra[1:0]];

    initial begin
        for (int i = 0; i < 4; i++) mem[i] = 15'h5A5A;
    end

    always @(posedge clk) begin
        if (ram_we) mem[ram_wa] <= ram_di;
    end

    sdp_wdma_cmd_sfifo_ctrl dut (
        .nvdla_core_clk(clk),
        .nvdla_core_rst(rst),
        .wr_pvld(wr_pvld),
        .wr_prdy(wr_prdy),
        .wr_pd(wr_pd),
        .rd_pvld(rd_pvld),
        .rd_prdy(rd_prdy),
        .rd_pd(rd_pd),
        .ram_we(ram_we),
        .ram_wa(ram_wa),
        .ram_di(ram_di),
        .ram_ra(ram_ra),
        .ram_dout(ram_dout),
        .pwrbus_ram_pd(pwrbus_ram_pd),
        .fifo_count(fifo_count),
        .fifo_idle(fifo_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Invariants, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("inv_count_le4", int'(fifo_count <= 3'd4), 1);
            chk("inv_ra2_zero", int'(ram_ra[2]), 0);
            chk("inv_no_we_full", int'(ram_we && fifo_count == 3'd4), 0);
        end
    end

    // Inputs change 1ns after the rising edge. Outputs are checked 4ns later,
    // which is before the next rising edge.
    task automatic drive(input logic r, input logic wv, input logic [14:0] d, input logic rr);
        rst     = r;
        wr_pvld = wv;
        wr_pd   = d;
        rd_prdy = rr;
        #4;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic        wv;
        logic [14:0] wd;
        logic        rr;
        logic        e_wprdy;
        logic        e_rpvld;
        logic [14:0] e_rpd;
        logic [2:0]  e_cnt;
        logic        e_we;
        logic        e_idle;
    } vec_t;

    vec_t vecs [14];

    logic [14:0] q [$];
    logic [14:0] prev_pd;
    logic        prev_stall;

    initial begin
        //          rst  wv  wd        rr   wprdy rpvld rpd       cnt   we    idle
        vecs[0]  = '{1'b1, 1'b1, 15'h0AAA, 1'b0, 1'b0, 1'b0, 15'h0000, 3'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 15'h0000, 1'b0, 1'b1, 1'b0, 15'h0000, 3'd0, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 1'b1, 15'h0001, 1'b0, 1'b1, 1'b0, 15'h0000, 3'd0, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 15'h0002, 1'b0, 1'b1, 1'b1, 15'h0001, 3'd1, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 15'h0003, 1'b0, 1'b1, 1'b1, 15'h0001, 3'd2, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 15'h0004, 1'b0, 1'b1, 1'b1, 15'h0001, 3'd3, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 15'h0005, 1'b0, 1'b0, 1'b1, 15'h0001, 3'd4, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 15'h0005, 1'b0, 1'b0, 1'b1, 15'h0001, 3'd4, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 15'h0000, 1'b1, 1'b0, 1'b1, 15'h0001, 3'd4, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 15'h0000, 1'b1, 1'b1, 1'b1, 15'h0002, 3'd3, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 15'h0000, 1'b1, 1'b1, 1'b1, 15'h0003, 3'd2, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 15'h0000, 1'b1, 1'b1, 1'b1, 15'h0004, 3'd1, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 15'h0000, 1'b1, 1'b1, 1'b0, 15'h0000, 3'd0, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 15'h0000, 1'b1, 1'b1, 1'b0, 15'h0000, 3'd0, 1'b0, 1'b1};

        pwrbus_ram_pd = 32'h0;
        rst = 1'b1; wr_pvld = 1'b0; wr_pd = 15'h0; rd_prdy = 1'b0;
        @(posedge clk); @(posedge clk); #1;

        // Table: reset cycle, fill to full, then drain past empty.
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].rst, vecs[i].wv, vecs[i].wd, vecs[i].rr);
            chk($sformatf("tbl%0d_wr_prdy", i), int'(wr_prdy), int'(vecs[i].e_wprdy));
            chk($sformatf("tbl%0d_rd_pvld", i), int'(rd_pvld), int'(vecs[i].e_rpvld));
            chk($sformatf("tbl%0d_count", i), int'(fifo_count), int'(vecs[i].e_cnt));
            chk($sformatf("tbl%0d_ram_we", i), int'(ram_we), int'(vecs[i].e_we));
            chk($sformatf("tbl%0d_idle", i), int'(fifo_idle), int'(vecs[i].e_idle));
            if (vecs[i].e_rpvld) chk($sformatf("tbl%0d_rd_pd", i), int'(rd_pd), int'(vecs[i].e_rpd));
            next_cycle();
        end

        // Streaming: write and read every cycle. Each payload shows up one cycle
        // after its write, and the pointers wrap twice.
        for (int k = 0; k < 12; k++) begin
            drive(1'b0, k < 10, 15'h7F00 + 15'(k), 1'b1);
            if (k == 0 || k == 11) begin
                chk("strm_rd_pvld_lo", int'(rd_pvld), 0);
                chk("strm_count0", int'(fifo_count), 0);
            end else begin
                chk("strm_rd_pvld", int'(rd_pvld), 1);
                chk("strm_rd_pd", int'(rd_pd), 32'h7F00 + k - 1);
                chk("strm_count1", int'(fifo_count), 1);
            end
            next_cycle();
        end

        // Reset while three entries are held, then a fresh write must read back.
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 15'h0111 * 15'(k + 1), 1'b0);
            next_cycle();
        end
        drive(1'b0, 1'b0, 15'h0, 1'b0);
        chk("rst3_count_before", int'(fifo_count), 3);
        next_cycle();
        drive(1'b1, 1'b1, 15'h7777, 1'b0);
        chk("rst3_wr_prdy_in_rst", int'(wr_prdy), 0);
        chk("rst3_ram_we_in_rst", int'(ram_we), 0);
        next_cycle();
        drive(1'b0, 1'b1, 15'h1234, 1'b0);
        chk("rst3_rd_pvld_after", int'(rd_pvld), 0);
        chk("rst3_count_after", int'(fifo_count), 0);
        next_cycle();
        drive(1'b0, 1'b0, 15'h0, 1'b1);
        chk("rst3_rd_pvld_new", int'(rd_pvld), 1);
        chk("rst3_rd_pd_new", int'(rd_pd), 32'h1234);
        chk("rst3_count_new", int'(fifo_count), 1);
        next_cycle();
        drive(1'b0, 1'b0, 15'h0, 1'b0);
        chk("rst3_empty_again", int'(fifo_count), 0);

        // Random traffic against a queue model.
        q.delete();
        prev_stall = 1'b0;
        prev_pd = 15'h0;
        for (int c = 0; c < 2000; c++) begin
            next_cycle();
            drive(1'b0, $urandom_range(0, 99) < 60, 15'($urandom), $urandom_range(0, 99) < 45);
            chk("rnd_wr_prdy", int'(wr_prdy), int'(q.size() != 4));
            chk("rnd_rd_pvld", int'(rd_pvld), int'(q.size() != 0));
            chk("rnd_count", int'(fifo_count), q.size());
            chk("rnd_idle", int'(fifo_idle), int'(q.size() == 0 && !wr_pvld));
            if (q.size() != 0) chk("rnd_rd_pd", int'(rd_pd), int'(q[0]));
            if (prev_stall) chk("rnd_pd_stable", int'(rd_pd), int'(prev_pd));
            prev_stall = (q.size() != 0) && !rd_prdy;
            prev_pd = rd_pd;
            begin
                logic do_wr;
                logic do_rd;
                do_wr = wr_pvld && (q.size() != 4);
                do_rd = rd_prdy && (q.size() != 0);
                if (do_rd) void'(q.pop_front());
                if (do_wr) q.push_back(wr_pd);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
